// File: rtl/jcnt_match_capture_if.sv
// Bus bundle for jcnt_match_capture: counter control, compare setup,
// capture data and the valid/ack/overrun handshake.
//   master: sequencer/consumer side (drives en, dir, clr, cmp_*, data_in,
//           ack, ovr_clr; observes counter and capture outputs)
//   slave : the counter/capture block itself
interface jcnt_match_capture_if #(
  parameter int WIDTH  = 4,
  parameter int DWIDTH = 4,
  parameter int NCMP   = 2
);
  localparam int SW = (NCMP > 1) ? $clog2(NCMP) : 1;

  logic                    en;
  logic                    dir;
  logic                    clr;
  logic [NCMP*WIDTH-1:0]   cmp_val;
  logic [NCMP-1:0]         cmp_en;
  logic [DWIDTH-1:0]       data_in;
  logic                    ack;
  logic                    ovr_clr;
  logic [WIDTH-1:0]        jcnt_out;
  logic [DWIDTH-1:0]       data_out;
  logic                    valid;
  logic [SW-1:0]           src;
  logic [NCMP-1:0]         hit;
  logic                    wrap;
  logic                    ovr;

  modport master (
    output en, dir, clr, cmp_val, cmp_en, data_in, ack, ovr_clr,
    input  jcnt_out, data_out, valid, src, hit, wrap, ovr
  );

  modport slave (
    input  en, dir, clr, cmp_val, cmp_en, data_in, ack, ovr_clr,
    output jcnt_out, data_out, valid, src, hit, wrap, ovr
  );
endinterface

// File: rtl/jcnt_match_capture.sv
// Johnson counter with NCMP programmable compare channels. A match on any
// enabled channel captures data_in into a held register with valid/ack
// handshake, lowest-index source channel, per-channel hit pulse and a sticky
// overrun flag.
//   clk   : clock, all state on rising edge
//   n_rst : asynchronous active-low reset
//   bus   : jcnt_match_capture_if slave (en/dir/clr, cmp_val/cmp_en,
//           data_in, ack, ovr_clr in; jcnt_out, data_out, valid, src, hit,
//           wrap, ovr out)
module jcnt_match_capture #(
  parameter int WIDTH  = 4,
  parameter int DWIDTH = 4,
  parameter int NCMP   = 2
) (
  input  logic                  clk,
  input  logic                  n_rst,
  jcnt_match_capture_if.slave   bus
);
  localparam int SW = (NCMP > 1) ? $clog2(NCMP) : 1;

  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  cnt_step;
  logic              fresh;
  logic              wrap_r;
  logic [NCMP-1:0]   match;
  logic [SW-1:0]     match_lo;
  logic              capture;
  logic [DWIDTH-1:0] data_r;
  logic              valid_r;
  logic [SW-1:0]     src_r;
  logic [NCMP-1:0]   hit_r;
  logic              ovr_r;

  always_comb begin
    cnt_step = '0;
    if (bus.dir) cnt_step = {~cnt[0], cnt[WIDTH-1:1]};
    else         cnt_step = {cnt[WIDTH-2:0], ~cnt[WIDTH-1]};
  end

  // fresh marks the first cycle after a load so a stalled counter matches once.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt    <= '0;
      fresh  <= 1'b1;
      wrap_r <= 1'b0;
    end else if (bus.clr) begin
      cnt    <= '0;
      fresh  <= 1'b1;
      wrap_r <= 1'b0;
    end else if (bus.en) begin
      cnt    <= cnt_step;
      fresh  <= 1'b1;
      wrap_r <= (cnt_step == '0);
    end else begin
      fresh  <= 1'b0;
      wrap_r <= 1'b0;
    end
  end

  always_comb begin
    match    = '0;
    match_lo = '0;
    for (int unsigned i = 0; i < NCMP; i++)
      match[i] = bus.cmp_en[i] & fresh & (cnt == bus.cmp_val[i*WIDTH +: WIDTH]);
    // Walk downward so the lowest matching index is the one left standing.
    for (int unsigned i = NCMP; i > 0; i--)
      if (match[i-1]) match_lo = SW'(i - 1);
  end

  assign capture = |match;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_r  <= '0;
      valid_r <= 1'b0;
      src_r   <= '0;
      hit_r   <= '0;
      ovr_r   <= 1'b0;
    end else begin
      hit_r <= match;
      // A new overrun takes precedence over a simultaneous ovr_clr.
      if (capture && valid_r && !bus.ack) ovr_r <= 1'b1;
      else if (bus.ovr_clr)               ovr_r <= 1'b0;
      if (capture) begin
        data_r  <= bus.data_in;
        src_r   <= match_lo;
        valid_r <= 1'b1;
      end else if (bus.ack) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign bus.jcnt_out = cnt;
  assign bus.data_out = data_r;
  assign bus.valid    = valid_r;
  assign bus.src      = src_r;
  assign bus.hit      = hit_r;
  assign bus.wrap     = wrap_r;
  assign bus.ovr      = ovr_r;
endmodule

// File: tb/tb_jcnt_match_capture.sv
module tb_jcnt_match_capture;
  localparam int W  = 4;
  localparam int DW = 4;
  localparam int NC = 2;
  localparam int L  = 2 * W;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  jcnt_match_capture_if #(.WIDTH(W), .DWIDTH(DW), .NCMP(NC)) bus ();

  jcnt_match_capture #(.WIDTH(W), .DWIDTH(DW), .NCMP(NC)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state: counter kept as a position 0..2W-1 in the sequence.
  int              m_k;
  bit              m_fresh;
  logic [DW-1:0]   m_data;
  bit              m_valid;
  int              m_src;
  logic [NC-1:0]   m_hit;
  bit              m_wrap;
  bit              m_ovr;

  // Sequence position -> pattern: k ones fill from the LSB, then zeros
  // fill from the LSB.
  function automatic logic [W-1:0] pat(int k);
    if (k <= W) return W'((1 << k) - 1);
    return W'(((1 << W) - 1) << (k - W));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_fresh = 1; m_data = '0; m_valid = 0;
    m_src = 0; m_hit = '0; m_wrap = 0; m_ovr = 0;
  endtask

  task automatic model_edge();
    logic [NC-1:0] mt;
    int lo;
    mt = '0;
    lo = -1;
    for (int i = 0; i < NC; i++) begin
      logic [NC*W-1:0] cv;
      cv = bus.cmp_val;
      if (bus.cmp_en[i] && m_fresh && pat(m_k) == cv[i*W +: W]) begin
        mt[i] = 1'b1;
        if (lo < 0) lo = i;
      end
    end
    m_hit = mt;
    if (mt != '0) begin
      if (m_valid && !bus.ack) m_ovr = 1;
      else if (bus.ovr_clr)    m_ovr = 0;
      m_data  = bus.data_in;
      m_src   = lo;
      m_valid = 1;
    end else begin
      if (bus.ack)     m_valid = 0;
      if (bus.ovr_clr) m_ovr = 0;
    end
    if (bus.clr) begin
      m_k = 0; m_fresh = 1; m_wrap = 0;
    end else if (bus.en) begin
      m_k = bus.dir ? (m_k + L - 1) % L : (m_k + 1) % L;
      m_fresh = 1;
      m_wrap = (m_k == 0);
    end else begin
      m_fresh = 0; m_wrap = 0;
    end
  endtask

  task automatic compare_all();
    chk("jcnt_out", 32'(bus.jcnt_out), 32'(pat(m_k)));
    chk("data_out", 32'(bus.data_out), 32'(m_data));
    chk("valid",    32'(bus.valid),    32'(m_valid));
    chk("src",      32'(bus.src),      32'(m_src));
    chk("hit",      32'(bus.hit),      32'(m_hit));
    chk("wrap",     32'(bus.wrap),     32'(m_wrap));
    chk("ovr",      32'(bus.ovr),      32'(m_ovr));
  endtask

  task automatic step();
    @(posedge clk);
    if (!n_rst) model_reset();
    else        model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    int wraps;
    int hits;
    n_rst = 1'b0;
    bus.en = 1'b1; bus.dir = 1'b0; bus.clr = 1'b0;
    bus.cmp_val = '0; bus.cmp_en = '0; bus.data_in = '0;
    bus.ack = 1'b0; bus.ovr_clr = 1'b0;
    model_reset();

    // Reset held with en active and data toggling
    repeat (4) begin
      bus.data_in = DW'($urandom);
      step();
    end
    chk("rst_jcnt", 32'(bus.jcnt_out), 32'h0);

    // Free run, compares disabled: wrap every 2W steps
    n_rst = 1'b1;
    wraps = 0;
    repeat (2 * L) begin
      step();
      wraps += int'(bus.wrap);
    end
    chk("wrap_count", 32'(wraps), 32'd2);

    // Capture on ch0 (0011) then overrun on ch1 (1110)
    bus.cmp_val = {4'b1110, 4'b0011};
    bus.cmp_en  = 2'b11;
    bus.data_in = 4'h0;
    repeat (2) step();
    bus.data_in = 4'hA;
    step();
    chk("cap0_data", 32'(bus.data_out), 32'hA);
    chk("cap0_src",  32'(bus.src),      32'h0);
    chk("cap0_hit",  32'(bus.hit),      32'h1);
    chk("cap0_vld",  32'(bus.valid),    32'h1);
    repeat (2) step();
    bus.data_in = 4'h5;
    step();
    chk("cap1_data", 32'(bus.data_out), 32'h5);
    chk("cap1_src",  32'(bus.src),      32'h1);
    chk("cap1_ovr",  32'(bus.ovr),      32'h1);

    // Stall at 0011: one capture only
    repeat (4) step();
    chk("stall_pos", 32'(bus.jcnt_out), 32'h3);
    bus.en = 1'b0;
    hits = 0;
    repeat (10) begin
      step();
      hits += int'(bus.hit != '0);
    end
    chk("stall_hits", 32'(hits), 32'd1);
    bus.ack = 1'b1;
    step();
    chk("ack_vld", 32'(bus.valid), 32'h0);
    bus.ack = 1'b0;
    repeat (3) step();
    chk("ack_hold", 32'(bus.valid), 32'h0);

    // Shared pattern, then ack coinciding with capture
    bus.ovr_clr = 1'b1;
    step();
    bus.ovr_clr = 1'b0;
    bus.cmp_val = {4'b0111, 4'b0111};
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    step();
    chk("share_hit", 32'(bus.hit), 32'h3);
    chk("share_src", 32'(bus.src), 32'h0);
    bus.en = 1'b1;
    repeat (L) step();
    bus.en = 1'b0;
    bus.ack = 1'b1;
    step();
    chk("ackcap_vld", 32'(bus.valid), 32'h1);
    chk("ackcap_ovr", 32'(bus.ovr),   32'h0);
    bus.ack = 1'b0;

    // Reverse run and clear
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    bus.cmp_val = {4'b0101, 4'b0000};
    bus.cmp_en  = 2'b01;
    bus.dir = 1'b1;
    bus.en  = 1'b1;
    step();
    chk("rev1", 32'(bus.jcnt_out), 32'h8);
    step();
    chk("rev2", 32'(bus.jcnt_out), 32'hC);
    bus.clr = 1'b1;
    step();
    chk("clr_cnt",  32'(bus.jcnt_out), 32'h0);
    chk("clr_wrap", 32'(bus.wrap),     32'h0);
    bus.clr = 1'b0;
    bus.en  = 1'b0;
    step();
    chk("clr_cap", 32'(bus.hit), 32'h1);

    // Overrun clear precedence, then reset mid-handshake
    bus.clr = 1'b1;
    step();
    bus.clr = 1'b0;
    bus.ovr_clr = 1'b1;
    step();
    chk("ovrclr_race", 32'(bus.ovr), 32'h1);
    step();
    chk("ovrclr_alone", 32'(bus.ovr), 32'h0);
    bus.ovr_clr = 1'b0;
    #2;
    n_rst = 1'b0;
    model_reset();
    #1;
    chk("arst_vld",  32'(bus.valid),    32'h0);
    chk("arst_data", 32'(bus.data_out), 32'h0);
    compare_all();
    #1;
    n_rst = 1'b1;
    step();
    chk("post_rst_cap", 32'(bus.valid), 32'h1);

    // Randomised traffic against the reference
    for (int s = 0; s < 400; s++) begin
      bus.en      = ($urandom_range(0, 3) != 0);
      bus.dir     = 1'($urandom);
      bus.clr     = ($urandom_range(0, 15) == 0);
      bus.ack     = ($urandom_range(0, 2) == 0);
      bus.ovr_clr = ($urandom_range(0, 7) == 0);
      bus.data_in = DW'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        bus.cmp_val = (NC*W)'($urandom);
        bus.cmp_en  = NC'($urandom);
      end
      step();
      if ($urandom_range(0, 63) == 0) begin
        #2;
        n_rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        n_rst = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
